pwm_multi_ch: RTL

//  Parametrised N-channel motor PWM generator; successor to the single-channel pwm_wrapper.

---
 rtl/pwm_multi_ch.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/pwm_multi_ch.sv
// ---------------------------------------------------------------------------
// pwm_multi_ch
//   N-channel motor PWM generator. Each channel takes a signed speed command:
//   the sign selects the H-bridge direction pin, the magnitude sets the duty
//   (in clocks per PWM period). Duty changes are slew-limited to RAMP_STEP
//   per period. A direction reversal first ramps the duty down to 0. It then
//   holds 0 for DIR_DEAD whole periods before the dir pin flips.
//
//   All channels share one period counter. Channel state advances only at the
//   period boundary (the cycle with cnt == PERIOD-1). A PWM period therefore
//   never contains a mix of two duties or two directions.
//
// Ports
//   CLK100MHZ    in   system clock
//   rst_n        in   synchronous reset, active-low
//   cmd_valid    in   command write strobe
//   cmd_ready    out  high whenever out of reset
//   cmd_ch       in   target channel index (indices >= NUM_CH are ignored)
//   cmd_data     in   signed speed command (two's complement)
//   spd          out  PWM outputs, one bit per channel
//   dir          out  direction outputs, 1 = reverse (negative command)
//   period_start out  one-cycle pulse on the first spd cycle of each period
// ---------------------------------------------------------------------------
module pwm_multi_ch #(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 16,
  parameter int PERIOD    = 1000,
  parameter int RAMP_STEP = 8,
  parameter int DIR_DEAD  = 2
) (
  input  logic                                          CLK100MHZ,
  input  logic                                          rst_n,
  input  logic                                          cmd_valid,
  output logic                                          cmd_ready,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cmd_ch,
  input  logic [DATA_W-1:0]                             cmd_data,
  output logic [NUM_CH-1:0]                             spd,
  output logic [NUM_CH-1:0]                             dir,
  output logic                                          period_start
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int DUTY_W = $clog2(PERIOD + 1);
  localparam int DEAD_W = (DIR_DEAD > 0) ? $clog2(DIR_DEAD + 1) : 1;
  // Width wide enough for both |cmd_data| (one extra bit for -2^(DATA_W-1))
  // and PERIOD, so the saturation compare is exact.
  localparam int MAG_W  = ((DATA_W + 1) > DUTY_W) ? (DATA_W + 1) : DUTY_W;
  // A step larger than the whole period is the same as an unlimited step.
  localparam int STEP_C = (RAMP_STEP > PERIOD) ? PERIOD : RAMP_STEP;

  localparam logic [DUTY_W-1:0] STEP     = DUTY_W'(STEP_C);
  localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(PERIOD);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [DEAD_W-1:0] DEAD_LD  = DEAD_W'(DIR_DEAD);
  localparam logic [DEAD_W-1:0] DEAD_ONE = DEAD_W'(1);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DEAD = 1'b1
  } ch_state_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [DUTY_W-1:0] tmag_q [NUM_CH];
  logic [DUTY_W-1:0] tmag_d [NUM_CH];
  logic              tneg_q [NUM_CH];
  logic              tneg_d [NUM_CH];
  logic [DUTY_W-1:0] duty_q [NUM_CH];
  logic [DUTY_W-1:0] duty_d [NUM_CH];
  logic [DEAD_W-1:0] dead_q [NUM_CH];
  logic [DEAD_W-1:0] dead_d [NUM_CH];
  ch_state_e         state_q[NUM_CH];
  ch_state_e         state_d[NUM_CH];
  logic [NUM_CH-1:0] dir_q, dir_d;

  logic [NUM_CH-1:0] spd_q, spd_d;
  logic [NUM_CH-1:0] dir_out_q, dir_out_d;
  logic              period_start_q, period_start_d;

  // -------------------------------------------------------------------------
  // Command interface
  //   Handshake: a write is taken on every clock edge where cmd_valid and
  //   cmd_ready are both high. cmd_ready is high whenever the block is out of
  //   reset, so the decoder never stalls. The source must hold cmd_ch and
  //   cmd_data stable while cmd_valid is high. A write lands in the channel's
  //   target register only; duty follows at the next period boundary, and the
  //   last write before that boundary wins.
  // -------------------------------------------------------------------------
  logic              cmd_fire;
  logic              cmd_neg;
  logic [DATA_W:0]   data_ext;
  logic [DATA_W:0]   abs_ext;
  logic [MAG_W-1:0]  abs_w;
  logic [DUTY_W-1:0] cmd_mag;

  assign cmd_ready = rst_n;
  assign cmd_fire  = cmd_valid & rst_n;

  always_comb begin : cmd_decode
    cmd_neg  = cmd_data[DATA_W-1];
    data_ext = {cmd_data[DATA_W-1], cmd_data};
    // Negation is done one bit wider, so -2^(DATA_W-1) has a valid magnitude.
    abs_ext  = cmd_neg ? (~data_ext + {{DATA_W{1'b0}}, 1'b1}) : data_ext;
    abs_w    = MAG_W'(abs_ext);
    if (abs_w > MAG_W'(PERIOD)) begin
      cmd_mag = DUTY_MAX;
    end else begin
      cmd_mag = DUTY_W'(abs_w);
    end
  end

  // -------------------------------------------------------------------------
  // Shared period counter
  // -------------------------------------------------------------------------
  logic boundary;

  assign boundary = (cnt_q == CNT_LAST);

  always_comb begin : cnt_next
    cnt_d = boundary ? '0 : (cnt_q + CNT_W'(1));
  end

  // -------------------------------------------------------------------------
  // Per-channel reversal request. A zero target never asks for a dir change,
  // whatever sign bit it was written with.
  // -------------------------------------------------------------------------
  logic [NUM_CH-1:0] rev_req;

  always_comb begin : rev_decode
    rev_req = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rev_req[i] = (tmag_q[i] != '0) && (tneg_q[i] != dir_q[i]);
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel FSM (RUN / DEAD), stepped once per period at the boundary
  // -------------------------------------------------------------------------
  always_comb begin : ch_next
    for (int i = 0; i < NUM_CH; i++) begin
      tmag_d[i]  = tmag_q[i];
      tneg_d[i]  = tneg_q[i];
      duty_d[i]  = duty_q[i];
      dead_d[i]  = dead_q[i];
      state_d[i] = state_q[i];
      dir_d[i]   = dir_q[i];

      if (boundary) begin
        case (state_q[i])
          ST_RUN: begin
            if (!rev_req[i]) begin
              // Slew toward the target magnitude, never overshooting it.
              if (duty_q[i] < tmag_q[i]) begin
                duty_d[i] = ((tmag_q[i] - duty_q[i]) > STEP) ?
                            (duty_q[i] + STEP) : tmag_q[i];
              end else begin
                duty_d[i] = ((duty_q[i] - tmag_q[i]) > STEP) ?
                            (duty_q[i] - STEP) : tmag_q[i];
              end
            end else if (duty_q[i] != '0) begin
              // Reversal pending: ramp down to 0 first.
              duty_d[i] = (duty_q[i] > STEP) ? (duty_q[i] - STEP) : '0;
            end else if (DIR_DEAD == 0) begin
              dir_d[i] = ~dir_q[i];
            end else begin
              dead_d[i]  = DEAD_LD;
              state_d[i] = ST_DEAD;
            end
          end
          ST_DEAD: begin
            // duty is already 0 here and stays 0 throughout DEAD.
            if (!rev_req[i]) begin
              // Command swung back to the current direction: abandon reversal.
              dead_d[i]  = '0;
              state_d[i] = ST_RUN;
            end else if (dead_q[i] == DEAD_ONE) begin
              dead_d[i]  = '0;
              dir_d[i]   = ~dir_q[i];
              state_d[i] = ST_RUN;
            end else begin
              dead_d[i] = dead_q[i] - DEAD_ONE;
            end
          end
          default: begin
            duty_d[i]  = '0;
            dead_d[i]  = '0;
            state_d[i] = ST_RUN;
          end
        endcase
      end

      // Target writes take effect for the next boundary, not this one.
      if (cmd_fire && (cmd_ch == CH_W'(i))) begin
        tmag_d[i] = cmd_mag;
        tneg_d[i] = cmd_neg;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output stage. spd compares against the current cnt and is registered, so
  // the spd window lags cnt by one cycle. period_start and dir are registered
  // with the same lag, so all pins change together at the start of a period.
  // -------------------------------------------------------------------------
  always_comb begin : out_next
    spd_d          = '0;
    dir_out_d      = dir_q;
    period_start_d = (cnt_q == '0);
    for (int i = 0; i < NUM_CH; i++) begin
      spd_d[i] = (DUTY_W'(cnt_q) < duty_q[i]);
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK100MHZ) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      dir_q          <= '0;
      spd_q          <= '0;
      dir_out_q      <= '0;
      period_start_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        tmag_q[i]  <= '0;
        tneg_q[i]  <= 1'b0;
        duty_q[i]  <= '0;
        dead_q[i]  <= '0;
        state_q[i] <= ST_RUN;
      end
    end else begin
      cnt_q          <= cnt_d;
      dir_q          <= dir_d;
      spd_q          <= spd_d;
      dir_out_q      <= dir_out_d;
      period_start_q <= period_start_d;
      for (int i = 0; i < NUM_CH; i++) begin
        tmag_q[i]  <= tmag_d[i];
        tneg_q[i]  <= tneg_d[i];
        duty_q[i]  <= duty_d[i];
        dead_q[i]  <= dead_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

  assign spd          = spd_q;
  assign dir          = dir_out_q;
  assign period_start = period_start_q;

endmodule
